alu_matrix_sequencer: RTL and testbench
=======================================

// Module: alu_matrix_sequencer
// PURPOSE
//  Initiator for the matrix ALU's sel/eleIn/eleOut port. Accepts an operation code plus an
//  operand stream (valid/ready) and writes the operands into the ALU, one element per sel code.
//  Fires the ALU operation, then reads the G matrix (or det) back out as a valid/ready result stream.
//  Sits between the host/UART front-end and the matrix ALU; it is the only driver of the ALU sel bus.
// PARAMETERS
//  DATA_W    32  element width; must equal the ALU element width
//  SEL_W     6   ALU select width
//  IDLE_SEL  27  parked sel code (read det: no writes, no op)
// PORTS
//  clk          in   1       system clock
//  reset        in   1       synchronous, active-high reset
//  start        in   1       op request; accepted only in IDLE with op<=5
//  op           in   3       0 transpose,1 add,2 sub,3 mul,4 scale,5 det; sampled on accept
//  in_valid     in   1       operand word valid
//  in_ready     out  1       operand word accepted when in_valid&in_ready
//  in_data      in   DATA_W  operand word (row-major)
//  out_valid    out  1       result word valid; held until out_ready
//  out_ready    in   1       result sink ready
//  out_data     out  DATA_W  result word (row-major G, or det)
//  out_last     out  1       high with final result word
//  busy         out  1       high in every state except IDLE
//  done         out  1       one-cycle pulse after last result is taken
//  alu_sel      out  SEL_W   registered sel to ALU
//  alu_ele_in   out  DATA_W  registered eleIn to ALU
//  alu_ele_out  in   DATA_W  eleOut from ALU (combinational from alu_sel)
// BEHAVIOUR
//  Reset: state IDLE, alu_sel=IDLE_SEL, alu_ele_in=0, out_data=0, out_valid/out_last/in_ready/
//   busy/done=0, counters=0. Reset mid-operation abandons the operation; the ALU is not cleaned.
//  States: IDLE -> LOAD -> EXEC -> SETTLE -> RSEL <-> RVAL -> DONE -> IDLE.
//  IDLE: start & op<=5 -> latch op, idx=0, LOAD. start with op 6/7 is ignored; start while busy is ignored.
//  LOAD: in_ready=1. Each handshake registers alu_sel=code(idx), alu_ele_in=in_data; idx++.
//   Word counts and codes: transpose/det 9 words -> 0..8 (E); add/sub/mul 18 words -> 0..17 (E then F);
//   scale 10 words -> first word sel 40 (c), then 0..8 (E). After the last word -> EXEC.
//   The last write's sel/data are presented in the EXEC-entry cycle. The ALU element latches hold on sel change.
//  EXEC: alu_sel = 28+op for exactly one cycle (ALU registers G/det on that edge) -> SETTLE.
//  SETTLE: alu_sel=IDLE_SEL for one cycle; ridx=0 -> RSEL.
//  RSEL: alu_sel=18+ridx (det: 27); next cycle out_data<=alu_ele_out, out_valid=1 -> RVAL.
//  RVAL: alu_sel held; out_valid, out_data and out_last are stable until out_ready.
//   On handshake, out_valid=0. If the word was last -> DONE, else ridx++ -> RSEL.
//   Result count: 9 words (G00..G22), or 1 word for det. out_last is asserted on word 9 (det: word 1).
//  DONE: done=1 for one cycle, alu_sel=IDLE_SEL -> IDLE.
//  Arithmetic: none locally; ALU results pass through bit-exact (32-bit wrap on sub/mul is not flagged).
//  Throughput: 1 operand/cycle in; 1 result/2 cycles out. Min latency last-in -> first out_valid = 4 cycles.
//  alu_sel never presents 0..17 or 40 outside LOAD, so no stray writes occur.
// CONFIGURATION
//  ALU_SEQ_PERF_EN defined: adds output perf_cycles[15:0]. It clears on start accept,
//   increments every busy cycle, saturates at 16'hFFFF, holds after DONE, and resets to 0.
//  ALU_SEQ_PERF_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  add: E=1..9, F=all 1 -> out 2,3..10; out_last on 10; done pulses once; alu_sel returns to 27.
//  mul: E=1..9, F=identity -> out 1..9 unchanged.
//  transpose: E=1..9 -> out 1,4,7,2,5,8,3,6,9.
//  scale: c=3, E=1..9 -> out 3,6..27. det: E=diag(2,3,4) -> single word 24 with out_last=1.
//  backpressure: out_ready low 5 cycles at word 4 -> out_data, out_valid and alu_sel stable; no word lost or duplicated.
//  reset after 5 LOAD words; start with op=6 -> IDLE next cycle, busy=0, alu_sel=27, in_ready=0; op=6 not accepted.

Source files
------------

// File: rtl/alu_matrix_sequencer.sv
// Sequencer that loads operands into the matrix ALU and streams its results back out.
// Optional build macro ALU_SEQ_PERF_EN adds the perf_cycles busy-cycle counter output.
module alu_matrix_sequencer #(
  parameter int DATA_W   = 32,
  parameter int SEL_W    = 6,
  parameter int IDLE_SEL = 27
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [SEL_W-1:0]  alu_sel,
  output logic [DATA_W-1:0] alu_ele_in,
  input  logic [DATA_W-1:0] alu_ele_out
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0]       perf_cycles
`endif
);

  localparam int SEL_G0   = 18;
  localparam int SEL_EXEC = 28;
  localparam int SEL_COEF = 40;

  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_SCALE = 3'd4;
  localparam logic [2:0] OP_DET   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_EXEC, S_SETTLE, S_RSEL, S_RVAL, S_DONE
  } state_t;

  state_t     state_reg;
  logic [2:0] op_reg;
  logic [4:0] idx_reg;
  logic [3:0] ridx_reg;
  logic       primed_reg;

  logic             start_accept;
  logic [4:0]       last_idx;
  logic             load_last;
  logic [SEL_W-1:0] load_code;
  logic [SEL_W-1:0] read_sel;
  logic [SEL_W-1:0] read_sel_next;
  logic             read_last;

  assign start_accept = (state_reg == S_IDLE) && start && (op <= 3'd5);

  always_comb begin
    last_idx = 5'd8;
    case (op_reg)
      OP_ADD, OP_SUB, OP_MUL: last_idx = 5'd17;
      OP_SCALE:               last_idx = 5'd9;
      default:                last_idx = 5'd8;
    endcase
  end

  assign load_last = (idx_reg == last_idx);

  // Scale sends the coefficient first, so its element codes lag the word index by one.
  always_comb begin
    load_code = SEL_W'(idx_reg);
    if (op_reg == OP_SCALE) begin
      if (idx_reg == 5'd0) load_code = SEL_W'(SEL_COEF);
      else                 load_code = SEL_W'(idx_reg - 5'd1);
    end
  end

  assign read_sel      = (op_reg == OP_DET) ? SEL_W'(IDLE_SEL)
                                            : SEL_W'(SEL_G0) + SEL_W'(ridx_reg);
  assign read_sel_next = SEL_W'(SEL_G0) + SEL_W'(ridx_reg) + SEL_W'(1);
  assign read_last     = (op_reg == OP_DET) || (ridx_reg == 4'd8);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      op_reg     <= 3'd0;
      idx_reg    <= 5'd0;
      ridx_reg   <= 4'd0;
      primed_reg <= 1'b0;
      alu_sel    <= SEL_W'(IDLE_SEL);
      alu_ele_in <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start_accept) begin
            op_reg    <= op;
            idx_reg   <= 5'd0;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            state_reg <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid && in_ready) begin
            alu_sel    <= load_code;
            alu_ele_in <= in_data;
            idx_reg    <= idx_reg + 5'd1;
            if (load_last) begin
              in_ready  <= 1'b0;
              state_reg <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          alu_sel   <= SEL_W'(SEL_EXEC) + SEL_W'(op_reg);
          state_reg <= S_SETTLE;
        end
        S_SETTLE: begin
          alu_sel    <= SEL_W'(IDLE_SEL);
          ridx_reg   <= 4'd0;
          primed_reg <= 1'b0;
          state_reg  <= S_RSEL;
        end
        S_RSEL: begin
          // First visit only presents the read code; later visits arrive already primed.
          if (!primed_reg) begin
            alu_sel    <= read_sel;
            primed_reg <= 1'b1;
          end else begin
            out_data  <= alu_ele_out;
            out_valid <= 1'b1;
            out_last  <= read_last;
            state_reg <= S_RVAL;
          end
        end
        S_RVAL: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (read_last) begin
              alu_sel   <= SEL_W'(IDLE_SEL);
              done      <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              ridx_reg  <= ridx_reg + 4'd1;
              alu_sel   <= read_sel_next;
              state_reg <= S_RSEL;
            end
          end
        end
        S_DONE: begin
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset)                                 perf_cycles <= 16'd0;
    else if (start_accept)                     perf_cycles <= 16'd0;
    else if (busy && perf_cycles != 16'hFFFF)  perf_cycles <= perf_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_matrix_sequencer.sv
// Bench for alu_matrix_sequencer: a behavioural matrix ALU answers the sel bus,
// a vector table drives the operations and a queue scoreboard checks the result stream.
module tb_alu_matrix_sequencer;
  localparam int DW = 32;
  localparam int SW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    op;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [SW-1:0] alu_sel;
  logic [DW-1:0] alu_ele_in;
  logic [DW-1:0] alu_ele_out;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0]   perf_cycles;
`endif

  always #5 clk = ~clk;

  alu_matrix_sequencer #(.DATA_W(DW), .SEL_W(SW), .IDLE_SEL(27)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done),
    .alu_sel(alu_sel), .alu_ele_in(alu_ele_in), .alu_ele_out(alu_ele_out)
`ifdef ALU_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  // Behavioural matrix ALU: element writes on sel 0..17/40, operation on 28..33.
  logic [31:0] e_m [9];
  logic [31:0] f_m [9];
  logic [31:0] g_m [9];
  logic [31:0] c_m;
  logic [31:0] det_m;

  always @(posedge clk) begin
    int s;
    s = int'(alu_sel);
    if (s <= 8) e_m[s] <= alu_ele_in;
    else if (s <= 17) f_m[s-9] <= alu_ele_in;
    else if (s == 40) c_m <= alu_ele_in;
    else if (s >= 28 && s <= 32) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          case (s)
            28: g_m[i*3+j] <= e_m[j*3+i];
            29: g_m[i*3+j] <= e_m[i*3+j] + f_m[i*3+j];
            30: g_m[i*3+j] <= e_m[i*3+j] - f_m[i*3+j];
            31: g_m[i*3+j] <= e_m[i*3]*f_m[j] + e_m[i*3+1]*f_m[3+j] + e_m[i*3+2]*f_m[6+j];
            default: g_m[i*3+j] <= c_m * e_m[i*3+j];
          endcase
        end
      end
    end else if (s == 33) begin
      det_m <= e_m[0]*(e_m[4]*e_m[8] - e_m[5]*e_m[7])
             - e_m[1]*(e_m[3]*e_m[8] - e_m[5]*e_m[6])
             + e_m[2]*(e_m[3]*e_m[7] - e_m[4]*e_m[6]);
    end
  end

  always_comb begin
    alu_ele_out = '0;
    if (alu_sel >= 6'd18 && alu_sel <= 6'd26) alu_ele_out = g_m[int'(alu_sel) - 18];
    else if (alu_sel == 6'd27)                alu_ele_out = det_m;
  end

  typedef struct packed {
    logic [2:0]        op;
    logic [4:0]        nin;
    logic [3:0]        nout;
    logic [17:0][31:0] din;
    logic [8:0][31:0]  dout;
  } vec_t;

  vec_t        vecs [5];
  logic [31:0] sb_q [$];
  int          checks = 0;
  int          passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic send_words(input vec_t v, input int count, output bit ok);
    int t;
    ok = 1'b1;
    for (int i = 0; i < count; i++) begin
      in_valid = 1'b1;
      in_data  = v.din[i];
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        check("in_ready_timeout", 32'(in_ready), 32'd1);
        ok = 1'b0;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input int vi, input int bp_word, input bit chk_lat);
    vec_t        v;
    bit          ok;
    int          t;
    logic [31:0] d0;
    logic [31:0] exp;
    logic [SW-1:0] s0;
    v = vecs[vi];
    @(negedge clk);
    start = 1'b1;
    op    = v.op;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < int'(v.nout); k++) sb_q.push_back(v.dout[k]);
    send_words(v, int'(v.nin), ok);
    if (!ok) begin
      sb_q.delete();
      return;
    end
    for (int k = 0; k < int'(v.nout); k++) begin
      out_ready = (k == bp_word) ? 1'b0 : 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!out_valid && t < 50);
      if (!out_valid) begin
        check("out_valid_timeout", 32'(out_valid), 32'd1);
        sb_q.delete();
        out_ready = 1'b1;
        return;
      end
      if (k == 0 && chk_lat) check("latency", 32'(t), 32'd4);
      if (k == bp_word) begin
        d0 = out_data;
        s0 = alu_sel;
        repeat (5) begin
          @(negedge clk);
          check("bp_valid", 32'(out_valid), 32'd1);
          check("bp_data", out_data, d0);
          check("bp_sel", 32'(alu_sel), 32'(s0));
        end
        out_ready = 1'b1;
      end
      exp = sb_q.pop_front();
      $display("txn op=%0d word=%0d data=%0d last=%0b", v.op, k, out_data, out_last);
      check("result_data", out_data, exp);
      check("result_last", 32'(out_last), (k == int'(v.nout) - 1) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    check("done_pulse", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd1);
    check("valid_dropped", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("done_cleared", 32'(done), 32'd0);
    check("busy_cleared", 32'(busy), 32'd0);
    check("sel_parked", 32'(alu_sel), 32'd27);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    // Vector table: add, mul, transpose, scale, det.
    for (int v = 0; v < 5; v++) vecs[v] = '0;
    vecs[0].op = 3'd1; vecs[0].nin = 5'd18; vecs[0].nout = 4'd9;
    vecs[1].op = 3'd3; vecs[1].nin = 5'd18; vecs[1].nout = 4'd9;
    vecs[2].op = 3'd0; vecs[2].nin = 5'd9;  vecs[2].nout = 4'd9;
    vecs[3].op = 3'd4; vecs[3].nin = 5'd10; vecs[3].nout = 4'd9;
    vecs[4].op = 3'd5; vecs[4].nin = 5'd9;  vecs[4].nout = 4'd1;
    for (int i = 0; i < 9; i++) begin
      vecs[0].din[i]     = 32'(i + 1);
      vecs[0].din[9+i]   = 32'd1;
      vecs[0].dout[i]    = 32'(i + 2);
      vecs[1].din[i]     = 32'(i + 1);
      vecs[1].din[9+i]   = (i % 4 == 0) ? 32'd1 : 32'd0;
      vecs[1].dout[i]    = 32'(i + 1);
      vecs[2].din[i]     = 32'(i + 1);
      vecs[2].dout[i]    = 32'((i % 3) * 3 + (i / 3) + 1);
      vecs[3].din[i+1]   = 32'(i + 1);
      vecs[3].dout[i]    = 32'(3 * (i + 1));
    end
    vecs[3].din[0] = 32'd3;
    vecs[4].din[0] = 32'd2;
    vecs[4].din[4] = 32'd3;
    vecs[4].din[8] = 32'd4;
    vecs[4].dout[0] = 32'd24;

    reset = 1'b1; start = 1'b0; op = 3'd0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_sel", 32'(alu_sel), 32'd27);
    check("rst_ele_in", alu_ele_in, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_vec(0, -1, 1'b1);
    run_vec(1, 3, 1'b0);
    for (int v = 2; v < 5; v++) run_vec(v, -1, 1'b0);

    // Reset part-way through loading an add, then try an illegal opcode.
    @(negedge clk);
    start = 1'b1; op = 3'd1;
    @(negedge clk);
    start = 1'b0;
    send_words(vecs[0], 5, ok);
    check("midload_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_sel", 32'(alu_sel), 32'd27);
    start = 1'b1; op = 3'd6;
    @(negedge clk);
    start = 1'b0;
    check("op6_busy", 32'(busy), 32'd0);
    check("op6_in_ready", 32'(in_ready), 32'd0);
    check("op6_sel", 32'(alu_sel), 32'd27);
    @(negedge clk);
    check("op6_still_idle", 32'(busy), 32'd0);

    run_vec(4, -1, 1'b0);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
